pl0_sequencer: RTL
==================

# pl0_sequencer

Instruction fetch/issue controller for `pl0_machine`. It reads 16-bit instruction words from a synchronous program memory, presents them one at a time on the machine's `instruction` port with a valid/ready handshake, and advances the program counter sequentially or to a branch target reported by the datapath. It stops on a halt opcode and keeps a count of retired instructions for debug.

## Interface
- `ADDR_W`, 8: program counter and program-memory address width.
- `RESET_PC`, 0: first fetch address after reset and after restart.
- `HALT_OP`, 4'hF: opcode value (instruction bits [15:12]) that halts sequencing.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  single-cycle pulse; leaves IDLE/HALT and begins fetching.
- `prog_rd`  out  1  program-memory read strobe.
- `prog_addr`  out  ADDR_W  read address, valid while `prog_rd`=1.
- `prog_data`  in  16  read data, valid exactly one cycle after `prog_rd`.
- `instruction`  out  16  instruction word to the datapath, {opcode[15:12], operand[11:0]}.
- `instr_valid`  out  1  `instruction` is valid and held stable.
- `instr_ready`  in  1  datapath accepts `instruction` this cycle.
- `branch_valid`  in  1  accepted instruction is a taken branch; sampled only on the accept cycle.
- `branch_target`  in  ADDR_W  next PC when `branch_valid`=1 on accept.
- `pc`  out  ADDR_W  address of the current/next instruction.
- `halted`  out  1  high in HALT.
- `retired`  out  16  accepted-instruction count, saturating at 16'hFFFF.

## Operation
- States: IDLE, FETCH, LOAD, ISSUE, HALT (plus PAUSE when configured).
- IDLE: outputs quiescent; `start`=1 -> FETCH.
- FETCH: `prog_rd`=1, `prog_addr`=`pc` for exactly one cycle -> LOAD.
- LOAD: register `prog_data` into `instruction` -> ISSUE.
- ISSUE: `instr_valid`=1, `instruction` held until accept (`instr_valid && instr_ready`).
- On accept: `retired` += 1 (saturating). If opcode == `HALT_OP` -> HALT, `pc` unchanged. Else `pc` <= `branch_valid` ? `branch_target` : `pc`+1, wrapping modulo 2^ADDR_W, -> FETCH.
- `branch_valid` outside an accept cycle is ignored.
- HALT: `halted`=1; `start`=1 -> `pc`<=`RESET_PC`, `retired`<=0, -> FETCH. `start` ignored in FETCH/LOAD/ISSUE.
- Halt opcode still completes the handshake; the datapath sees it once.

## Timing
- Reset values: state IDLE, `pc`=`RESET_PC`, `instruction`=0, `instr_valid`=0, `prog_rd`=0, `prog_addr`=`RESET_PC`, `halted`=0, `retired`=0.
- `start` at cycle N -> `prog_rd` at N+1, `instr_valid` at N+3.
- Accept at cycle M (non-halt) -> next `prog_rd` at M+1, next `instr_valid` at M+3; peak rate one instruction per 3 cycles.
- `instr_valid` deasserts the cycle after accept; never drops without accept.
- `halted` rises the cycle after accepting a halt opcode.
- Reset mid-operation: all state cleared immediately; an in-flight read's `prog_data` is discarded.
- PC wrap: `pc`=2^ADDR_W-1, non-branch accept -> `pc`=0.

## Configuration
- `PL0_SEQ_STEP_EN` defined: adds input `step` (1 bit); each non-halt accept enters PAUSE instead of FETCH, `pc` already updated; `step`=1 -> FETCH. `step` ignored in other states. Reset state unchanged.
- Undefined: no `step` port, no PAUSE state; accept goes directly to FETCH.

## Test plan
- Memory {0:0x102A, 1:0x103A, 2:0xF000}, `instr_ready`=1, pulse `start` -> 0x102A, 0x103A, 0xF000 issued 3 cycles apart; `halted`=1, `retired`=3, `pc`=2.
- Hold `instr_ready`=0 for 5 cycles in ISSUE -> `instruction` stable, `instr_valid`=1 throughout, `retired` unchanged.
- Accept at pc=1 with `branch_valid`=1, `branch_target`=0x40 -> next `prog_addr`=0x40; `branch_valid` pulsed outside accept -> no effect.
- ADDR_W=8, `RESET_PC`=0xFF, non-halt word at 0xFF -> next `prog_addr`=0x00.
- Assert `reset` during LOAD -> outputs at reset values that cycle; `start` restarts from `RESET_PC`; `start` in HALT clears `retired` to 0.
- With `PL0_SEQ_STEP_EN`: after each accept no `prog_rd` until `step` pulse; `prog_rd` the cycle after `step`.

Source files
------------

// File: rtl/pl0_sequencer.sv
// Instruction fetch/issue controller for pl0_machine: fetch -> load -> issue with valid/ready.
// Optional single-step pause after each accepted instruction when PL0_SEQ_STEP_EN is defined.
module pl0_sequencer #(
  parameter int               ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [3:0]       HALT_OP  = 4'hF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
`ifdef PL0_SEQ_STEP_EN
  input  logic              step,
`endif
  output logic              prog_rd,
  output logic [ADDR_W-1:0] prog_addr,
  input  logic [15:0]       prog_data,
  output logic [15:0]       instruction,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              branch_valid,
  input  logic [ADDR_W-1:0] branch_target,
  output logic [ADDR_W-1:0] pc,
  output logic              halted,
  output logic [15:0]       retired
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_ISSUE,
`ifdef PL0_SEQ_STEP_EN
    S_PAUSE,
`endif
    S_HALT
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [15:0]       instr_q, instr_d;
  logic [15:0]       retired_q, retired_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      instr_q   <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    retired_d = retired_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end
      S_FETCH: state_d = S_LOAD;
      S_LOAD: begin
        instr_d = prog_data;
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        if (instr_ready) begin
          retired_d = (retired_q == 16'hFFFF) ? retired_q : retired_q + 16'd1;
          if (instr_q[15:12] == HALT_OP) begin
            state_d = S_HALT;
          end else begin
            // pc+1 wraps naturally at the address width
            pc_d = branch_valid ? branch_target : pc_q + 1'b1;
`ifdef PL0_SEQ_STEP_EN
            state_d = S_PAUSE;
`else
            state_d = S_FETCH;
`endif
          end
        end
      end
`ifdef PL0_SEQ_STEP_EN
      S_PAUSE: begin
        if (step) state_d = S_FETCH;
      end
`endif
      S_HALT: begin
        if (start) begin
          pc_d      = RESET_PC;
          retired_d = '0;
          state_d   = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign prog_rd     = (state_q == S_FETCH);
  assign prog_addr   = pc_q;
  assign instruction = instr_q;
  assign instr_valid = (state_q == S_ISSUE);
  assign pc          = pc_q;
  assign halted      = (state_q == S_HALT);
  assign retired     = retired_q;

endmodule
